// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon Says player-input front end.
package simon_pkg;
  typedef enum logic {IDLE, COLLECT} entry_state_t;
  localparam int KEY_W = 4;
  localparam int NBTN = 16;
  function automatic logic [KEY_W-1:0] lowest_set(input logic [NBTN-1:0] v);
    lowest_set = '0;
    for (int i = NBTN - 1; i >= 0; i--) if (v[i]) lowest_set = KEY_W'(i);
  endfunction
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: two-flop synchroniser plus whole-vector debouncer for the pushbuttons.
module pb_debounce
  import simon_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] pb,
  output logic [NBTN-1:0] stable
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [NBTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // cand holds the previous synchronised sample, so cnt is the length of the current run of a non-stable value
  always_comb begin
    sync1_d = pb;
    sync2_d = sync1_q;
    cand_d = sync2_q;
    cnt_d = (sync2_q == stable_q) ? '0 :
            (sync2_q != cand_q) ? CW'(1) :
            cnt_q + CW'(cnt_q != CW'(DEBOUNCE));
    stable_d = (sync2_q != stable_q && sync2_q == cand_q && cnt_q == CW'(DEBOUNCE - 1)) ? sync2_q : stable_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q <= cand_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/pb_entry.sv
// pb_entry: debounced key-press encoder and fixed-length key entry collector for the game FSM.
module pb_entry
  import simon_pkg::*;
#(
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT = 1000,
  parameter int NDIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NBTN-1:0]                pb,
  input  logic                           arm,
  output logic [KEY_W*NDIGITS-1:0]       entry,
  output logic [$clog2(NDIGITS+1)-1:0]   nkeys,
  output logic [KEY_W-1:0]               key,
  output logic                           strobe,
  output logic                           done,
  output logic                           timeout,
  output logic                           busy
);
  localparam int NW = $clog2(NDIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [NBTN-1:0] stable, prev_q, prev_d;
  logic ev_q, ev_d;
  logic [KEY_W-1:0] code_q, code_d, key_q, key_d;
  entry_state_t state_q, state_d;
  logic [KEY_W*NDIGITS-1:0] entry_q, entry_d;
  logic [NW-1:0] nkeys_q, nkeys_d;
  logic [TW-1:0] timer_q, timer_d;
  logic strobe_q, strobe_d, done_q, done_d, timeout_q, timeout_d;
  pb_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb),
    .stable(stable)
  );
  always_comb begin
    prev_d = stable;
    ev_d = (|stable) && !(|prev_q);
    code_d = lowest_set(stable);
  end
  // timer restarts at 1 on arm so timeout lands TIMEOUT cycles after the arm cycle itself
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    nkeys_d = nkeys_q;
    key_d = key_q;
    timer_d = timer_q + TW'(timer_q != TW'(TIMEOUT));
    strobe_d = 1'b0;
    done_d = 1'b0;
    timeout_d = 1'b0;
    if (arm) begin
      state_d = COLLECT;
      entry_d = '0;
      nkeys_d = '0;
      key_d = '0;
      timer_d = TW'(1);
    end else if (state_q == COLLECT) begin
      if (ev_q) begin
        entry_d[int'(nkeys_q)*KEY_W +: KEY_W] = code_q;
        nkeys_d = nkeys_q + NW'(1);
        key_d = code_q;
        strobe_d = 1'b1;
        timer_d = '0;
        done_d = (nkeys_q == NW'(NDIGITS - 1));
        state_d = done_d ? IDLE : COLLECT;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      ev_q <= 1'b0;
      code_q <= '0;
      state_q <= IDLE;
      entry_q <= '0;
      nkeys_q <= '0;
      key_q <= '0;
      timer_q <= '0;
      strobe_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ev_q <= ev_d;
      code_q <= code_d;
      state_q <= state_d;
      entry_q <= entry_d;
      nkeys_q <= nkeys_d;
      key_q <= key_d;
      timer_q <= timer_d;
      strobe_q <= strobe_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign entry = entry_q;
  assign nkeys = nkeys_q;
  assign key = key_q;
  assign strobe = strobe_q;
  assign done = done_q;
  assign timeout = timeout_q;
  assign busy = (state_q == COLLECT) || done_q || timeout_q;
endmodule
